ws2812_frame_ctrl: RTL

Frame sequencer for the WS2812 one-bit PWM encoder. It fetches NUM_LEDS 24-bit GRB pixels over a ready/valid interface and serialises them MSB-first, one bit per encoder slot. It gates the encoder run signal and inserts the latch/reset low period after each frame. It sits between the pixel source (pattern generator or frame RAM) and the encoder's `one_bit`/`wait_signal` inputs.

---
 rtl/ws2812_frame_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ws2812_frame_ctrl
//  Description : Frame sequencer for a WS2812 one-bit PWM encoder. Fetches
//                NUM_LEDS GRB pixels over ready/valid, serialises them MSB
//                first (one bit per encoder slot), gates the encoder run
//                signal and inserts the latch low period after each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_ctrl #(
    parameter int CLK_PER_BIT  = 78,
    parameter int NUM_LEDS     = 16,
    parameter int IDX_W        = 8,
    parameter int RESET_CYCLES = 5200
) (
    input  logic             clk,
    input  logic             inter_rst,
    input  logic             start,
    input  logic [23:0]      pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [IDX_W-1:0] pix_idx,
    output logic             enc_en,
    output logic             bit_out,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int c_slot_w  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int c_latch_w = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int c_cnt_w   = $clog2(NUM_LEDS + 1);

    localparam logic [c_slot_w-1:0]  c_slot_last  = c_slot_w'(CLK_PER_BIT - 1);
    localparam logic [c_latch_w-1:0] c_latch_last = c_latch_w'(RESET_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_num_leds   = c_cnt_w'(NUM_LEDS);
    localparam logic [c_cnt_w-1:0]   c_last_pix   = c_cnt_w'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0]     c_idx_last   = IDX_W'(NUM_LEDS - 1);
    localparam logic [4:0]           c_bit_last   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [23:0]           r_shift;
    logic [23:0]           r_hold;
    logic                  r_hold_valid;
    logic [c_slot_w-1:0]   r_slot;
    logic [4:0]            r_bit;
    logic [c_cnt_w-1:0]    r_fetched;
    logic [c_cnt_w-1:0]    r_sent;
    logic [IDX_W-1:0]      r_idx;
    logic [c_latch_w-1:0]  r_latch;
    logic                  r_underrun;

    logic                  w_slot_end;
    logic                  w_pix_end;
    logic                  w_hold_room;
    logic                  w_hs;

    assign w_slot_end  = (r_slot == c_slot_last);
    assign w_pix_end   = w_slot_end && (r_bit == c_bit_last);
    // Holding register can take the next pixel only while empty and the frame is not fully fetched
    assign w_hold_room = !r_hold_valid && (r_fetched < c_num_leds);
    assign w_hs        = pix_valid && pix_ready;

    assign pix_idx  = r_idx;
    assign underrun = r_underrun;

    // State register
    always_ff @(posedge clk or negedge inter_rst) begin
        if (!inter_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_state_next = r_state;
        pix_ready    = 1'b0;
        enc_en       = 1'b0;
        bit_out      = 1'b0;
        frame_done   = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                enc_en    = 1'b1;
                bit_out   = r_shift[23];
                pix_ready = w_hold_room;
                if (w_pix_end) begin
                    if (r_sent == c_last_pix) begin
                        w_state_next = ST_LATCH;
                    end else if (!r_hold_valid && !(pix_valid && w_hold_room)) begin
                        // Next pixel missed its deadline: abandon the frame
                        w_state_next = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (r_latch == c_latch_last) begin
                    frame_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: pixel fetch, holding register, shift register and counters
    always_ff @(posedge clk or negedge inter_rst) begin
        if (!inter_rst) begin
            r_shift      <= 24'd0;
            r_hold       <= 24'd0;
            r_hold_valid <= 1'b0;
            r_slot       <= '0;
            r_bit        <= 5'd0;
            r_fetched    <= '0;
            r_sent       <= '0;
            r_idx        <= '0;
            r_latch      <= '0;
            r_underrun   <= 1'b0;
        end else begin
            // Every accepted pixel advances the request index, saturating on the last pixel
            if (w_hs) begin
                r_fetched <= r_fetched + 1'b1;
                if (r_idx != c_idx_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_underrun   <= 1'b0;
                        r_idx        <= '0;
                        r_fetched    <= '0;
                        r_sent       <= '0;
                        r_hold_valid <= 1'b0;
                    end
                    r_slot  <= '0;
                    r_bit   <= 5'd0;
                    r_latch <= '0;
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        r_shift <= pix_data;
                    end
                    r_slot <= '0;
                    r_bit  <= 5'd0;
                end
                ST_SEND: begin
                    r_latch <= '0;
                    if (w_slot_end) begin
                        r_slot  <= '0;
                        r_shift <= {r_shift[22:0], 1'b0};
                        r_bit   <= (r_bit == c_bit_last) ? 5'd0 : r_bit + 5'd1;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                    if (w_pix_end) begin
                        r_sent <= r_sent + 1'b1;
                        if (r_sent != c_last_pix) begin
                            if (r_hold_valid) begin
                                r_shift      <= r_hold;
                                r_hold_valid <= 1'b0;
                            end else if (w_hs) begin
                                // Same-cycle arrival goes straight to the shifter
                                r_shift <= pix_data;
                            end else begin
                                r_underrun <= 1'b1;
                            end
                        end
                    end else if (w_hs) begin
                        r_hold       <= pix_data;
                        r_hold_valid <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_latch <= (r_latch == c_latch_last) ? '0 : r_latch + 1'b1;
                end
                default: begin
                    r_latch <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
